int4_dot_sequencer: RTL and testbench

INT4_DOT_SEQUENCER -- requirements
Module: int4_dot_sequencer

---
 rtl/int4_dot_sequencer_if.sv | 31 +++
 rtl/int4_dot_sequencer.sv | 118 +++++++++++
 tb/tb_int4_dot_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/int4_dot_sequencer_if.sv
// Job, RAM and dot-product-unit signals of the int4 dot-product sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface int4_dot_sequencer_if #(
  parameter int unsigned AWIDTH = 10,
  parameter int unsigned LWIDTH = 11
) ();
  logic              start;
  logic [AWIDTH-1:0] src_base;
  logic [LWIDTH-1:0] len;
  logic [AWIDTH-1:0] dst_addr;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [AWIDTH-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              wr_en;
  logic [AWIDTH-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [31:0]       cu_inp;
  logic [31:0]       cu_out;

  modport slave (
    input  start, src_base, len, dst_addr, rd_data, cu_out,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, cu_inp
  );

  modport master (
    output start, src_base, len, dst_addr, rd_data, cu_out,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, cu_inp
  );
endinterface

// File: rtl/int4_dot_sequencer.sv
// Streams len words from RAM through an external 4-cycle int4 dot-product unit,
// sums the results and writes the 32-bit total back to RAM.
module int4_dot_sequencer #(
  parameter int unsigned AWIDTH = 10,
  parameter int unsigned LWIDTH = 11
) (
  input logic                  clk,
  input logic                  reset,
  int4_dot_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StRead, StDrain, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] src_base_q, src_base_d;
  logic [LWIDTH-1:0] len_q, len_d;
  logic [AWIDTH-1:0] dst_q, dst_d;
  logic [LWIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [31:0]       acc_q, acc_d;
  // Stage 1 lines up with rd_data/cu_inp, stage 5 with the matching cu_out.
  logic [4:0]        vld_q, vld_d;

  logic              rd_en;
  logic [AWIDTH-1:0] rd_addr;
  logic              wr_en;
  logic [AWIDTH-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              done;

  always_comb begin
    state_d    = state_q;
    src_base_d = src_base_q;
    len_d      = len_q;
    dst_d      = dst_q;
    rd_cnt_d   = rd_cnt_q;
    acc_d      = acc_q;
    rd_en      = 1'b0;
    rd_addr    = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    done       = 1'b0;

    if (vld_q[4]) begin
      acc_d = acc_q + bus.cu_out;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          src_base_d = bus.src_base;
          len_d      = bus.len;
          dst_d      = bus.dst_addr;
          rd_cnt_d   = '0;
          acc_d      = '0;
          state_d    = (bus.len == '0) ? StWrite : StRead;
        end
      end
      StRead: begin
        rd_en    = 1'b1;
        rd_addr  = src_base_q + AWIDTH'(rd_cnt_q);
        rd_cnt_d = rd_cnt_q + LWIDTH'(1);
        if (rd_cnt_q == len_q - LWIDTH'(1)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Leave once only the final tag (being accumulated now) remains.
        if (vld_q[3:0] == '0) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        wr_en   = 1'b1;
        wr_addr = dst_q;
        wr_data = acc_q;
        state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    vld_d = {vld_q[3:0], rd_en};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      src_base_q <= '0;
      len_q      <= '0;
      dst_q      <= '0;
      rd_cnt_q   <= '0;
      acc_q      <= '0;
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      src_base_q <= src_base_d;
      len_q      <= len_d;
      dst_q      <= dst_d;
      rd_cnt_q   <= rd_cnt_d;
      acc_q      <= acc_d;
      vld_q      <= vld_d;
    end
  end

  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = done;
  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = rd_addr;
  assign bus.wr_en   = wr_en;
  assign bus.wr_addr = wr_addr;
  assign bus.wr_data = wr_data;
  assign bus.cu_inp  = vld_q[0] ? bus.rd_data : 32'h0;

endmodule

// File: tb/tb_int4_dot_sequencer.sv
// Scoreboard bench for int4_dot_sequencer: RAM and dot-product-unit models,
// expected reads/writes/done pushed at job issue and checked by a monitor.
module tb_int4_dot_sequencer;

  localparam int unsigned AW = 10;
  localparam int unsigned LW = 11;
  localparam int unsigned Depth = 1 << AW;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
  } rd_exp_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int4_dot_sequencer_if #(.AWIDTH(AW), .LWIDTH(LW)) bus ();

  int4_dot_sequencer #(.AWIDTH(AW), .LWIDTH(LW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [31:0]   mem [Depth];
  logic          fill;
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [31:0]   pre_data;
  logic          rd_vld;
  logic [31:0]   cu_pipe [4];
  int            cyc = 0;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  int      done_q[$];
  rd_exp_t mon_rd;
  wr_exp_t mon_wr;
  int      mon_done;

  int n_checks = 0;
  int n_pass = 0;

  function automatic logic [31:0] dot4(input logic [31:0] w);
    int s = 0;
    for (int k = 0; k < 4; k++) begin
      s += int'(w[8*k+4 +: 4]) * int'(w[8*k +: 4]);
    end
    return 32'(s);
  endfunction

  assign bus.cu_out = cu_pipe[3];

  // RAM with 1-cycle read latency, and a 4-cycle dot-product unit that emits
  // junk whenever its input is not a real operand word.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fill) begin
      for (int i = 0; i < int'(Depth); i++) mem[i] <= $urandom;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
    bus.rd_data <= bus.rd_en ? mem[bus.rd_addr] : $urandom;
    rd_vld      <= reset ? 1'b0 : bus.rd_en;
    cu_pipe[0]  <= rd_vld ? dot4(bus.cu_inp) : $urandom;
    cu_pipe[1]  <= cu_pipe[0];
    cu_pipe[2]  <= cu_pipe[1];
    cu_pipe[3]  <= cu_pipe[2];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_evt(input string name);
    n_checks++;
    $display("FAIL %s: got unexpected event, expected none (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rd_en) begin
        if (rd_q.size() == 0) fail_evt("rd_unexpected");
        else begin
          mon_rd = rd_q.pop_front();
          check("rd_addr", 64'(bus.rd_addr), 64'(mon_rd.addr));
          check("rd_cycle", 64'(cyc), 64'(mon_rd.cyc));
        end
      end
      if (bus.wr_en) begin
        check("rd_wr_overlap", 64'(bus.rd_en), 64'(0));
        if (wr_q.size() == 0) fail_evt("wr_unexpected");
        else begin
          mon_wr = wr_q.pop_front();
          check("wr_addr", 64'(bus.wr_addr), 64'(mon_wr.addr));
          check("wr_data", 64'(bus.wr_data), 64'(mon_wr.data));
          check("wr_cycle", 64'(cyc), 64'(mon_wr.cyc));
        end
      end
      if (bus.done) begin
        check("done_busy", 64'(bus.busy), 64'(1));
        if (done_q.size() == 0) fail_evt("done_unexpected");
        else begin
          mon_done = done_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(mon_done));
        end
      end
      if (rd_vld || bus.cu_inp != 32'h0) begin
        check("cu_inp", 64'(bus.cu_inp), rd_vld ? 64'(bus.rd_data) : 64'(0));
      end
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    pre_we = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 200) begin
      @(posedge clk);
      #1 t++;
    end
    if (t >= 200) fail_evt("idle_timeout");
  endtask

  task automatic wait_queues();
    int t = 0;
    while ((rd_q.size() != 0 || wr_q.size() != 0 || done_q.size() != 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (t >= 500) fail_evt("drain_timeout");
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    check({tag, "_done"}, 64'(bus.done), 64'(0));
    check({tag, "_rd_en"}, 64'(bus.rd_en), 64'(0));
    check({tag, "_wr_en"}, 64'(bus.wr_en), 64'(0));
    check({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'(0));
    check({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'(0));
    check({tag, "_wr_data"}, 64'(bus.wr_data), 64'(0));
    check({tag, "_cu_inp"}, 64'(bus.cu_inp), 64'(0));
  endtask

  // Start cycle is the current cycle; expectations come from the RAM image.
  task automatic run_job(input logic [AW-1:0] base, input int len, input logic [AW-1:0] dst,
                         input bit wait_done);
    logic [31:0]   acc = 32'h0;
    logic [AW-1:0] a;
    int            wr_cyc;
    wait_idle();
    for (int i = 0; i < len; i++) begin
      a = AW'(int'(base) + i);
      rd_q.push_back('{cyc: cyc + 1 + i, addr: a});
      acc += dot4(mem[a]);
    end
    wr_cyc = (len == 0) ? cyc + 1 : cyc + len + 6;
    wr_q.push_back('{cyc: wr_cyc, addr: dst, data: acc});
    done_q.push_back(wr_cyc + 1);
    bus.start = 1'b1;
    bus.src_base = base;
    bus.len = LW'(len);
    bus.dst_addr = dst;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.src_base = AW'($urandom);
    bus.len = LW'($urandom);
    bus.dst_addr = AW'($urandom);
    if (wait_done) wait_queues();
  endtask

  initial begin
    int t;
    reset = 1'b1;
    fill = 1'b1;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    bus.start = 1'b0;
    bus.src_base = '0;
    bus.len = '0;
    bus.dst_addr = '0;
    @(posedge clk);
    #1 fill = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    preload(10'd100, 32'h1111_1111);
    run_job(10'd100, 1, 10'd200, 1'b1);
    for (int i = 0; i < 4; i++) preload(AW'(300 + i), 32'hFFFF_FFFF);
    run_job(10'd300, 4, 10'd210, 1'b1);
    run_job(10'd77, 0, 10'd5, 1'b1);
    run_job(10'd1023, 2, 10'd220, 1'b1);

    // Start re-pulsed mid-READ must be ignored.
    run_job(10'd400, 8, 10'd230, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.src_base = 10'd10;
    bus.len = 11'd3;
    bus.dst_addr = 10'd99;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_queues();

    // Start held during the DONE cycle must be ignored.
    run_job(10'd600, 2, 10'd250, 1'b0);
    t = 0;
    while (!bus.done && t < 50) begin
      @(posedge clk);
      #1 t++;
    end
    if (t >= 50) fail_evt("done_timeout");
    bus.start = 1'b1;
    bus.src_base = 10'd20;
    bus.len = 11'd2;
    bus.dst_addr = 10'd98;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_queues();

    // Reset during DRAIN aborts the job; restart in the first cycle out of reset.
    run_job(10'd500, 3, 10'd240, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    wr_q.delete();
    done_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_zero("reset_drain");
    @(posedge clk);
    #1 reset = 1'b0;
    run_job(10'd500, 3, 10'd241, 1'b1);

    for (int j = 0; j < 30; j++) begin
      run_job(AW'($urandom), int'($urandom_range(0, 24)), AW'($urandom), 1'b0);
    end
    wait_queues();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
